mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Parametrised, elastic MEM→WB pipeline stage; successor of the fixed two-control-bit stall/clear register.
- Adds a valid/ready handshake with a 2-entry skid buffer, so a writeback stall does not combinationally back-propagate into MEM.
- Performs the write-back result mux.
- Provides a forwarding view to the hazard unit and a retired-write counter.

Parameters:
- DATA_W, 64, width of memory-read data, ALU result and write-back data
- RD_W, 5, destination register index width
- CTRL_W, 2, control bundle width; bit positions come from the package
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register, combinational in_ready
- CNT_W, 32, width of the retired-write counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush, drops all held entries
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  control bundle (memtoreg, regwrite)
- in_mem_data  in  DATA_W  load data from data memory
- in_alu_data  in  DATA_W  ALU result
- in_rd  in  RD_W  destination register
- out_valid  out  1  head entry valid
- out_ready  in  1  WB/register file accepts head
- out_ctrl  out  CTRL_W  head control bundle
- out_mem_data  out  DATA_W  head load data
- out_alu_data  out  DATA_W  head ALU result
- out_rd  out  RD_W  head destination register
- out_wb_data  out  DATA_W  memtoreg ? out_mem_data : out_alu_data
- fwd_en  out  1  out_valid & regwrite & (out_rd != 0)
- fwd_rd  out  RD_W  equals out_rd
- fwd_data  out  DATA_W  equals out_wb_data
- retire_cnt  out  CNT_W  count of accepted head entries with regwrite=1

Behaviour:
- Reset (rst_n low, async):
  - State is EMPTY.
  - All registered payloads, out_valid and retire_cnt are 0.
  - in_ready is 1.
- Transfers:
  - Accept = in_valid & in_ready.
  - Retire = out_valid & out_ready.
  - Latency from accept to out_valid is 1 cycle. There is no combinational in→out path.
- State machine for SKID=1: EMPTY, ONE (main register full), TWO (main and skid full). in_ready = (state != TWO), registered.
  - EMPTY: accept → ONE, main <= input.
  - ONE: accept & retire → ONE, main <= input. Accept & !retire → TWO, skid <= input. !accept & retire → EMPTY. Otherwise hold.
  - TWO: no accept possible. Retire → ONE, main <= skid. Otherwise hold.
- SKID=0: states are EMPTY and ONE only. in_ready = !out_valid | out_ready (combinational). Acts as a stall register.
- Ordering: strictly FIFO. The skid entry never overtakes main.
- Flush:
  - Takes priority over accept and retire in the same cycle.
  - Next state is EMPTY; payloads are zeroed.
  - A simultaneous input is discarded.
  - A simultaneous retire still counts toward retire_cnt, because WB has already consumed it.
- Stall: when out_ready=0, all out_* and fwd_* outputs hold stable.
- retire_cnt:
  - Increments by 1 on retire with out_ctrl[CTRL_REGWRITE]=1.
  - Wraps modulo 2^CTRL... specifically modulo 2^CNT_W.
  - Cleared only by reset; flush does not clear it.
- fwd_en is 0 whenever out_valid=0, regardless of stale payload. Register x0 is never forwarded.
- Payload fields are don't-care when their valid bit is 0, except after reset or flush, where they are 0.

Decomposition:
- Package pipe_pkg:
  - CTRL_MEMTOREG=0, CTRL_REGWRITE=1, CTRL_W default
  - State encoding ST_EMPTY/ST_ONE/ST_TWO
  - Packed payload struct {ctrl, mem_data, alu_data, rd}
- One sub-module, pipe_skid_buf: generic payload-width elastic buffer with flush, holding the state machine.
- mem_wb_stage instantiates pipe_skid_buf on the packed payload and adds the wb mux, forwarding logic and counter.

Test Plan:
- Reset mid-stream: assert rst_n=0 while in TWO → same cycle out_valid=0, retire_cnt=0, in_ready=1; after release, first accept of alu=0x10, rd=3 → out_valid next cycle, out_wb_data=0x10.
- Back-to-back, out_ready=1: stream A(alu=1, rd=1), B(mem=2, memtoreg=1, rd=2), C(alu=3, rd=3), all regwrite=1 → out_wb_data 1, 2, 3 on consecutive cycles; retire_cnt=3.
- Skid fill: out_ready=0, push A then B → state TWO, in_ready=0 on the cycle after B, head stays A; raise out_ready → A, then B, in order; in_ready=1 after A retires.
- Flush collision: TWO with in_valid=1, out_ready=1, flush=1 → next cycle out_valid=0, in_ready=1; retire_cnt +1 if the head had regwrite; the input is never seen at the output.
- Forwarding gating: head rd=0, regwrite=1 → fwd_en=0. Head rd=7, regwrite=0 → fwd_en=0. Head rd=7, regwrite=1, alu=0xABCD → fwd_en=1, fwd_rd=7, fwd_data=0xABCD.
- Counter wrap and SKID=0 build (CNT_W=4): 17 regwrite retires → retire_cnt=1. With out_ready=0 and out_valid=1 → in_ready=0 the same cycle; with out_ready=1 → in_ready=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM->WB pipeline slice: control bit positions,
// elastic-buffer state encoding and the default-width payload layout.
package pipe_pkg;

  localparam int CTRL_W_DEF    = 2;
  localparam int DATA_W_DEF    = 64;
  localparam int RD_W_DEF      = 5;
  localparam int CTRL_MEMTOREG = 0;
  localparam int CTRL_REGWRITE = 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  // Field order matches the flat vector packed by mem_wb_stage (ctrl in the MSBs).
  typedef struct packed {
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [DATA_W_DEF-1:0] mem_data;
    logic [DATA_W_DEF-1:0] alu_data;
    logic [RD_W_DEF-1:0]   rd;
  } wb_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic elastic buffer with flush. SKID=1 gives a two-entry skid buffer with
// in_ready taken straight from the state register; SKID=0 is a single stall register.
//
// state    | meaning
// ST_EMPTY | nothing held, output invalid
// ST_ONE   | main register holds the head entry
// ST_TWO   | main holds the head, skid holds the next entry (SKID=1 only)
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W    = 8,
  parameter int SKID = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept, retire;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state_q != ST_TWO);
    end else begin : g_stall
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  assign accept = in_valid & in_ready;
  assign retire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && retire) begin
            main_d = in_data;
          end else if (accept) begin
            // Only reachable with SKID=1; the stall register refuses input while full.
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (retire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (retire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Elastic MEM->WB stage: buffers the MEM payload, selects write-back data,
// exposes the head to the hazard unit and counts retired register writes.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_alu_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_wb_data,
  output logic              fwd_en,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int PW = CTRL_W + 2 * DATA_W + RD_W;

  logic [PW-1:0]    in_payload, out_payload;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  assign in_payload = {in_ctrl, in_mem_data, in_alu_data, in_rd};

  pipe_skid_buf #(
    .W    (PW),
    .SKID (SKID)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {out_ctrl, out_mem_data, out_alu_data, out_rd} = out_payload;

  assign out_wb_data = out_ctrl[CTRL_MEMTOREG] ? out_mem_data : out_alu_data;

  // x0 is hard-wired zero, so a write to it must never be forwarded.
  assign fwd_en   = out_valid & out_ctrl[CTRL_REGWRITE] & (out_rd != '0);
  assign fwd_rd   = out_rd;
  assign fwd_data = out_wb_data;

  assign retire = out_valid & out_ready;

  // WB has consumed the head even when a flush lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (retire && out_ctrl[CTRL_REGWRITE]) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus a randomized run against
// a queue-based reference, on a SKID=1 build and a SKID=0, CNT_W=4 build.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        flush, in_valid, in_ready, out_valid, out_ready, fwd_en;
  logic [1:0]  in_ctrl, out_ctrl;
  logic [63:0] in_mem_data, in_alu_data, out_mem_data, out_alu_data, out_wb_data, fwd_data;
  logic [4:0]  in_rd, out_rd, fwd_rd;
  logic [31:0] retire_cnt;

  logic        s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready, s0_fwd_en;
  logic [1:0]  s0_in_ctrl, s0_out_ctrl;
  logic [63:0] s0_in_mem_data, s0_in_alu_data, s0_out_mem_data, s0_out_alu_data;
  logic [63:0] s0_out_wb_data, s0_fwd_data;
  logic [4:0]  s0_in_rd, s0_out_rd, s0_fwd_rd;
  logic [3:0]  s0_retire_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [63:0] mem;
    logic [63:0] alu;
    logic [4:0]  rd;
  } ent_t;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_mem_data(in_mem_data), .in_alu_data(in_alu_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_mem_data(out_mem_data), .out_alu_data(out_alu_data), .out_rd(out_rd),
    .out_wb_data(out_wb_data), .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire_cnt(retire_cnt)
  );

  mem_wb_stage #(.SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_ctrl(s0_in_ctrl),
    .in_mem_data(s0_in_mem_data), .in_alu_data(s0_in_alu_data), .in_rd(s0_in_rd),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_ctrl(s0_out_ctrl),
    .out_mem_data(s0_out_mem_data), .out_alu_data(s0_out_alu_data), .out_rd(s0_out_rd),
    .out_wb_data(s0_out_wb_data), .fwd_en(s0_fwd_en), .fwd_rd(s0_fwd_rd), .fwd_data(s0_fwd_data),
    .retire_cnt(s0_retire_cnt)
  );

  task automatic idle_inputs();
    flush = 0; in_valid = 0; out_ready = 0; in_ctrl = 0; in_mem_data = 0; in_alu_data = 0; in_rd = 0;
    s0_flush = 0; s0_in_valid = 0; s0_out_ready = 0; s0_in_ctrl = 0;
    s0_in_mem_data = 0; s0_in_alu_data = 0; s0_in_rd = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    #2 rst_n = 1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [63:0] m, input logic [63:0] a, input logic [4:0] r);
    in_valid = 1; in_ctrl = c; in_mem_data = m; in_alu_data = a; in_rd = r;
  endtask

  task automatic test_reset();
    do_reset();
    out_ready = 0;
    drive(2'b10, 64'h0, 64'h111, 5'd1);
    @(negedge clk) drive(2'b10, 64'h0, 64'h222, 5'd2);
    @(negedge clk) in_valid = 0;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pre_two in_ready got=%b exp=0", in_ready); end
    rst_n = 0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_retire_cnt got=%0d exp=0", retire_cnt); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (out_alu_data !== 64'd0 || out_rd !== 5'd0) begin n_fail++; $display("FAIL rst_payload got alu=%h rd=%0d exp 0", out_alu_data, out_rd); end
    @(negedge clk);
    rst_n = 1;
    drive(2'b10, 64'h0, 64'h10, 5'd3);
    @(negedge clk) in_valid = 0;
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_first_valid got=%b exp=1", out_valid); end
    n_tests++; if (out_wb_data !== 64'h10) begin n_fail++; $display("FAIL rst_first_wb got=%h exp=10", out_wb_data); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1;
    drive(2'b10, 64'h0, 64'd1, 5'd1);
    @(negedge clk) drive(2'b11, 64'd2, 64'h0, 5'd2);
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_wb_data !== 64'd1) begin n_fail++; $display("FAIL b2b_A got v=%b wb=%0d exp v=1 wb=1", out_valid, out_wb_data); end
    @(negedge clk) drive(2'b10, 64'h0, 64'd3, 5'd3);
    #1;
    n_tests++; if (out_wb_data !== 64'd2 || out_rd !== 5'd2) begin n_fail++; $display("FAIL b2b_B got wb=%0d rd=%0d exp wb=2 rd=2", out_wb_data, out_rd); end
    @(negedge clk) in_valid = 0;
    #1;
    n_tests++; if (out_wb_data !== 64'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_C got wb=%0d v=%b exp wb=3 v=1", out_wb_data, out_valid); end
    @(negedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got v=%b exp=0", out_valid); end
    n_tests++; if (retire_cnt !== 32'd3) begin n_fail++; $display("FAIL b2b_cnt got=%0d exp=3", retire_cnt); end
  endtask

  task automatic test_skid_fill();
    do_reset();
    out_ready = 0;
    drive(2'b10, 64'h0, 64'hA, 5'd4);
    @(negedge clk) drive(2'b10, 64'h0, 64'hB, 5'd5);
    #1;
    n_tests++; if (in_ready !== 1'b1 || out_alu_data !== 64'hA) begin n_fail++; $display("FAIL skid_one got rdy=%b alu=%h exp rdy=1 alu=a", in_ready, out_alu_data); end
    @(negedge clk) in_valid = 0;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_two_ready got=%b exp=0", in_ready); end
    n_tests++; if (out_alu_data !== 64'hA || out_valid !== 1'b1) begin n_fail++; $display("FAIL skid_two_head got alu=%h v=%b exp alu=a v=1", out_alu_data, out_valid); end
    @(negedge clk);
    #1;
    n_tests++; if (out_alu_data !== 64'hA || out_rd !== 5'd4 || fwd_data !== 64'hA) begin n_fail++; $display("FAIL skid_stall_hold got alu=%h rd=%0d fwd=%h exp a/4/a", out_alu_data, out_rd, fwd_data); end
    out_ready = 1;
    @(negedge clk);
    #1;
    n_tests++; if (out_alu_data !== 64'hB || out_valid !== 1'b1) begin n_fail++; $display("FAIL skid_second got alu=%h v=%b exp alu=b v=1", out_alu_data, out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_after got=%b exp=1", in_ready); end
    @(negedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0 || retire_cnt !== 32'd2) begin n_fail++; $display("FAIL skid_drain got v=%b cnt=%0d exp v=0 cnt=2", out_valid, retire_cnt); end
  endtask

  task automatic test_flush_collision();
    do_reset();
    out_ready = 0;
    drive(2'b10, 64'h0, 64'hA1, 5'd1);
    @(negedge clk) drive(2'b00, 64'h0, 64'hB2, 5'd2);
    @(negedge clk) drive(2'b10, 64'h0, 64'hC3, 5'd3);
    out_ready = 1;
    flush = 1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_two got=%b exp=0", in_ready); end
    @(negedge clk);
    flush = 0; in_valid = 0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
    n_tests++; if (retire_cnt !== 32'd1) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=1", retire_cnt); end
    n_tests++; if (out_alu_data !== 64'd0 || out_ctrl !== 2'd0) begin n_fail++; $display("FAIL flush_zero got alu=%h ctrl=%b exp 0", out_alu_data, out_ctrl); end
    @(negedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard got v=%b exp=0", out_valid); end
  endtask

  task automatic test_forwarding();
    do_reset();
    out_ready = 0;
    drive(2'b10, 64'h0, 64'h5, 5'd0);
    @(negedge clk) in_valid = 0;
    #1;
    n_tests++; if (out_valid !== 1'b1 || fwd_en !== 1'b0) begin n_fail++; $display("FAIL fwd_x0 got v=%b en=%b exp v=1 en=0", out_valid, fwd_en); end
    flush = 1;
    @(negedge clk) flush = 0;
    drive(2'b00, 64'h0, 64'h7, 5'd7);
    @(negedge clk) in_valid = 0;
    #1;
    n_tests++; if (out_valid !== 1'b1 || fwd_en !== 1'b0) begin n_fail++; $display("FAIL fwd_norw got v=%b en=%b exp v=1 en=0", out_valid, fwd_en); end
    flush = 1;
    @(negedge clk) flush = 0;
    #1;
    n_tests++; if (fwd_en !== 1'b0) begin n_fail++; $display("FAIL fwd_empty got en=%b exp=0", fwd_en); end
    drive(2'b10, 64'h0, 64'hABCD, 5'd7);
    @(negedge clk) in_valid = 0;
    #1;
    n_tests++; if (fwd_en !== 1'b1 || fwd_rd !== 5'd7 || fwd_data !== 64'hABCD) begin n_fail++; $display("FAIL fwd_hit got en=%b rd=%0d data=%h exp 1/7/abcd", fwd_en, fwd_rd, fwd_data); end
  endtask

  task automatic test_skid0_wrap();
    do_reset();
    #1;
    n_tests++; if (s0_retire_cnt !== 4'd0 || s0_in_ready !== 1'b1) begin n_fail++; $display("FAIL s0_reset got cnt=%0d rdy=%b exp 0/1", s0_retire_cnt, s0_in_ready); end
    s0_out_ready = 1;
    for (int i = 0; i < 17; i++) begin
      if (i != 0) @(negedge clk);
      s0_in_valid = 1; s0_in_ctrl = 2'b10; s0_in_alu_data = 64'(i + 1); s0_in_rd = 5'd1;
    end
    @(negedge clk) s0_in_valid = 0;
    #1;
    n_tests++; if (s0_retire_cnt !== 4'd0 || s0_out_valid !== 1'b1 || s0_out_wb_data !== 64'd17) begin n_fail++; $display("FAIL s0_wrap16 got cnt=%0d v=%b wb=%0d exp 0/1/17", s0_retire_cnt, s0_out_valid, s0_out_wb_data); end
    @(negedge clk);
    #1;
    n_tests++; if (s0_retire_cnt !== 4'd1 || s0_out_valid !== 1'b0) begin n_fail++; $display("FAIL s0_wrap17 got cnt=%0d v=%b exp 1/0", s0_retire_cnt, s0_out_valid); end
    s0_out_ready = 0;
    s0_in_valid = 1; s0_in_alu_data = 64'h99;
    @(negedge clk) s0_in_valid = 0;
    #1;
    n_tests++; if (s0_out_valid !== 1'b1 || s0_in_ready !== 1'b0) begin n_fail++; $display("FAIL s0_stall got v=%b rdy=%b exp 1/0", s0_out_valid, s0_in_ready); end
    s0_out_ready = 1;
    #1;
    n_tests++; if (s0_in_ready !== 1'b1) begin n_fail++; $display("FAIL s0_comb_ready got=%b exp=1", s0_in_ready); end
  endtask

  task automatic test_random();
    ent_t        q[$];
    ent_t        q0[$];
    ent_t        e;
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt0;
    logic        exp_rdy, exp_rdy0, acc, ret, acc0, ret0;
    do_reset();
    m_cnt = 0; m_cnt0 = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      e.ctrl = 2'($urandom_range(0, 3));
      e.mem  = {$urandom, $urandom};
      e.alu  = {$urandom, $urandom};
      e.rd   = 5'($urandom_range(0, 31));
      in_valid = ($urandom_range(0, 9) < 6); out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 19) == 0);
      in_ctrl = e.ctrl; in_mem_data = e.mem; in_alu_data = e.alu; in_rd = e.rd;
      s0_in_valid = in_valid; s0_out_ready = out_ready; s0_flush = flush;
      s0_in_ctrl = e.ctrl; s0_in_mem_data = e.mem; s0_in_alu_data = e.alu; s0_in_rd = e.rd;
      #1;
      exp_rdy  = (q.size() < 2);
      exp_rdy0 = (q0.size() == 0) || out_ready;
      n_tests++; if (in_ready !== exp_rdy || out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_hs cyc=%0d got rdy=%b v=%b exp rdy=%b v=%b", cyc, in_ready, out_valid, exp_rdy, q.size() > 0); end
      n_tests++; if (retire_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, retire_cnt, m_cnt); end
      if (q.size() > 0) begin
        n_tests++;
        if (out_ctrl !== q[0].ctrl || out_mem_data !== q[0].mem || out_alu_data !== q[0].alu || out_rd !== q[0].rd) begin
          n_fail++; $display("FAIL rnd_head cyc=%0d got rd=%0d alu=%h exp rd=%0d alu=%h", cyc, out_rd, out_alu_data, q[0].rd, q[0].alu);
        end
        n_tests++;
        if (out_wb_data !== (q[0].ctrl[0] ? q[0].mem : q[0].alu) || fwd_data !== out_wb_data || fwd_rd !== q[0].rd
            || fwd_en !== (q[0].ctrl[1] && q[0].rd != 5'd0)) begin
          n_fail++; $display("FAIL rnd_wb cyc=%0d got wb=%h en=%b", cyc, out_wb_data, fwd_en);
        end
      end else begin
        n_tests++; if (fwd_en !== 1'b0) begin n_fail++; $display("FAIL rnd_fwd_idle cyc=%0d got=%b exp=0", cyc, fwd_en); end
      end
      n_tests++; if (s0_in_ready !== exp_rdy0 || s0_out_valid !== (q0.size() > 0) || s0_retire_cnt !== m_cnt0) begin n_fail++; $display("FAIL rnd_s0 cyc=%0d got rdy=%b v=%b cnt=%0d exp rdy=%b cnt=%0d", cyc, s0_in_ready, s0_out_valid, s0_retire_cnt, exp_rdy0, m_cnt0); end
      if (q0.size() > 0) begin
        n_tests++; if (s0_out_wb_data !== (q0[0].ctrl[0] ? q0[0].mem : q0[0].alu)) begin n_fail++; $display("FAIL rnd_s0_wb cyc=%0d got=%h", cyc, s0_out_wb_data); end
      end
      @(posedge clk);
      acc = in_valid && exp_rdy;       ret = (q.size() > 0) && out_ready;
      acc0 = in_valid && exp_rdy0;     ret0 = (q0.size() > 0) && out_ready;
      if (ret && q[0].ctrl[1]) m_cnt = m_cnt + 1;
      if (ret0 && q0[0].ctrl[1]) m_cnt0 = m_cnt0 + 1;
      if (flush) begin
        q.delete(); q0.delete();
      end else begin
        if (ret) void'(q.pop_front());
        if (acc) q.push_back(e);
        if (ret0) void'(q0.pop_front());
        if (acc0) q0.push_back(e);
      end
    end
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
    test_reset();
    test_back_to_back();
    test_skid_fill();
    test_flush_collision();
    test_forwarding();
    test_skid0_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
